// File: rtl/cursor_pos_sched.sv
// cursor_pos_sched: per-frame cursor position scheduler for the mouse overlay.
// Arbitrates between a PS/2 mouse (strobed samples) and a host requester
// (level request/ack) once per vblnk rising edge. Commits a clamped, frame-stable
// xpos/ypos pair to the overlay.
// Optional feature macro: CURSOR_TIMEOUT_EN. When defined, the cursor hides after
// TIMEOUT_FRAMES consecutive frames without a commit.
module cursor_pos_sched #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 768
`ifdef CURSOR_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_FRAMES = 120
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_valid,
  input  logic [11:0] host_xpos,
  input  logic [11:0] host_ypos,
  input  logic        host_req,
  output logic        host_ack,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        cursor_en,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned PW = 12;
  localparam int unsigned FW = 8;
  localparam logic [PW-1:0] X_LIM   = PW'(H_ACTIVE - 1);
  localparam logic [PW-1:0] Y_LIM   = PW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] X_RESET = PW'(H_ACTIVE / 2);
  localparam logic [PW-1:0] Y_RESET = PW'(V_ACTIVE / 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        state;
  logic          vblnk_d;
  logic          pend;
  logic [PW-1:0] pend_x;
  logic [PW-1:0] pend_y;
  logic          rr_host;    // 0: mouse wins a tie, 1: host wins a tie
  logic          host_win;
  logic [PW-1:0] stg_x;
  logic [PW-1:0] stg_y;

  logic          vblnk_rise_c;
  logic          sel_host_c;
  logic [PW-1:0] src_x_c;
  logic [PW-1:0] src_y_c;
  logic [PW-1:0] clamp_x_c;
  logic [PW-1:0] clamp_y_c;

`ifdef CURSOR_TIMEOUT_EN
  logic [FW-1:0] idle_cnt;
  logic [FW-1:0] idle_inc_c;
  logic          idle_hide_c;
`endif

  // Source selection and clamping of the winning position
  always_comb begin
    vblnk_rise_c = vblnk && !vblnk_d;
    sel_host_c   = host_req && (!pend || rr_host);
    src_x_c      = sel_host_c ? host_xpos : pend_x;
    src_y_c      = sel_host_c ? host_ypos : pend_y;
    clamp_x_c    = (src_x_c > X_LIM) ? X_LIM : src_x_c;
    clamp_y_c    = (src_y_c > Y_LIM) ? Y_LIM : src_y_c;
  end

`ifdef CURSOR_TIMEOUT_EN
  // Saturating idle-frame increment and hide decision
  always_comb begin
    idle_inc_c  = (idle_cnt == {FW{1'b1}}) ? idle_cnt : idle_cnt + FW'(1);
    idle_hide_c = (32'(idle_inc_c) >= TIMEOUT_FRAMES);
  end
`endif

  // Mouse capture, arbitration FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vblnk_d   <= 1'b0;
      pend      <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      rr_host   <= 1'b0;
      host_win  <= 1'b0;
      stg_x     <= '0;
      stg_y     <= '0;
      host_ack  <= 1'b0;
      xpos      <= X_RESET;
      ypos      <= Y_RESET;
      cursor_en <= 1'b1;
      frame_cnt <= '0;
`ifdef CURSOR_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      vblnk_d  <= vblnk;
      host_ack <= 1'b0;

      if (mouse_valid) begin
        pend_x <= mouse_xpos;
        pend_y <= mouse_ypos;
        pend   <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (vblnk_rise_c) state <= ST_ARB;
        end

        ST_ARB: begin
          if (!pend && !host_req) begin
            state <= ST_IDLE;
`ifdef CURSOR_TIMEOUT_EN
            idle_cnt <= idle_inc_c;
            if (idle_hide_c) cursor_en <= 1'b0;
`endif
          end else begin
            if (pend && host_req) rr_host <= ~rr_host;
            host_win <= sel_host_c;
            stg_x    <= clamp_x_c;
            stg_y    <= clamp_y_c;
            state    <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          state <= ST_IDLE;
          if (host_win && !host_req) begin
            // Host withdrew its request: nothing is committed this frame
`ifdef CURSOR_TIMEOUT_EN
            idle_cnt <= idle_inc_c;
            if (idle_hide_c) cursor_en <= 1'b0;
`endif
          end else begin
            xpos      <= stg_x;
            ypos      <= stg_y;
            frame_cnt <= frame_cnt + FW'(1);
            cursor_en <= 1'b1;
`ifdef CURSOR_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            if (host_win) host_ack <= 1'b1;
            else if (!mouse_valid) pend <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_pos_sched.sv
// Directed self-checking bench for cursor_pos_sched (default build).
module tb_cursor_pos_sched;

  logic        clk;
  logic        rst;
  logic        vblnk;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_valid;
  logic [11:0] host_xpos;
  logic [11:0] host_ypos;
  logic        host_req;
  logic        host_ack;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        cursor_en;
  logic [7:0]  frame_cnt;

  int checks;
  int errors;
  int ack_cnt;
  logic [7:0] exp_fc;

  cursor_pos_sched dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .mouse_valid (mouse_valid),
    .host_xpos   (host_xpos),
    .host_ypos   (host_ypos),
    .host_req    (host_req),
    .host_ack    (host_ack),
    .xpos        (xpos),
    .ypos        (ypos),
    .cursor_en   (cursor_en),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (host_ack === 1'b1) ack_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One mouse sample strobe
  task automatic mouse_strobe(input logic [11:0] x, input logic [11:0] y);
    mouse_xpos  = x;
    mouse_ypos  = y;
    mouse_valid = 1'b1;
    tick();
    mouse_valid = 1'b0;
  endtask

  // Raise vblnk and advance to cycle 3 (commit visible)
  task automatic frame_to_commit();
    vblnk = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic frame_end();
    vblnk = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (xpos !== 12'd512) begin errors++; $display("FAIL reset_xpos got %0d exp 512", xpos); end
    checks++; if (ypos !== 12'd384) begin errors++; $display("FAIL reset_ypos got %0d exp 384", ypos); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", host_ack); end
    checks++; if (cursor_en !== 1'b1) begin errors++; $display("FAIL reset_cursor_en got %b exp 1", cursor_en); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    for (int f = 0; f < 2; f++) begin
      frame_to_commit();
      frame_end();
    end
    checks++; if (xpos !== 12'd512 || ypos !== 12'd384) begin errors++; $display("FAIL idle_pos got %0d,%0d exp 512,384", xpos, ypos); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL idle_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL idle_ack got %0d exp 0", ack_cnt); end
  endtask

  task automatic test_mouse();
    mouse_strobe(12'd100, 12'd50);
    vblnk = 1'b1;
    tick();
    tick();
    checks++; if (xpos !== 12'd512) begin errors++; $display("FAIL mouse_early got %0d exp 512", xpos); end
    tick();
    exp_fc = exp_fc + 8'd1;
    checks++; if (xpos !== 12'd100 || ypos !== 12'd50) begin errors++; $display("FAIL mouse_pos got %0d,%0d exp 100,50", xpos, ypos); end
    checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL mouse_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
    frame_end();
  endtask

  task automatic test_clamp_rr();
    int ack0;
    ack0 = ack_cnt;
    host_xpos = 12'd5;
    host_ypos = 12'd6;
    host_req  = 1'b1;
    mouse_strobe(12'd2000, 12'd900);
    frame_to_commit();
    exp_fc = exp_fc + 8'd1;
    checks++; if (xpos !== 12'd1023 || ypos !== 12'd767) begin errors++; $display("FAIL clamp_pos got %0d,%0d exp 1023,767", xpos, ypos); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL clamp_ack got %b exp 0", host_ack); end
    frame_end();
    frame_to_commit();
    exp_fc = exp_fc + 8'd1;
    checks++; if (xpos !== 12'd5 || ypos !== 12'd6) begin errors++; $display("FAIL rr_host_pos got %0d,%0d exp 5,6", xpos, ypos); end
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rr_host_ack got %b exp 1", host_ack); end
    checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL rr_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
    host_req = 1'b0;
    tick();
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b exp 0", host_ack); end
    frame_end();
    checks++; if (ack_cnt - ack0 !== 1) begin errors++; $display("FAIL ack_count got %0d exp 1", ack_cnt - ack0); end
  endtask

  task automatic test_pend_keep();
    mouse_strobe(12'd20, 12'd30);
    vblnk = 1'b1;
    tick();
    tick();
    mouse_xpos  = 12'd10;
    mouse_ypos  = 12'd10;
    mouse_valid = 1'b1;
    tick();
    mouse_valid = 1'b0;
    exp_fc = exp_fc + 8'd1;
    checks++; if (xpos !== 12'd20 || ypos !== 12'd30) begin errors++; $display("FAIL keep_first got %0d,%0d exp 20,30", xpos, ypos); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (xpos !== 12'd20 || frame_cnt !== exp_fc) begin errors++; $display("FAIL vblnk_held got x=%0d fc=%0d exp x=20 fc=%0d", xpos, frame_cnt, exp_fc); end
    frame_end();
    frame_to_commit();
    exp_fc = exp_fc + 8'd1;
    checks++; if (xpos !== 12'd10 || ypos !== 12'd10) begin errors++; $display("FAIL keep_second got %0d,%0d exp 10,10", xpos, ypos); end
    checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL keep_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
    frame_end();
  endtask

  task automatic test_withdraw();
    int ack0;
    ack0 = ack_cnt;
    host_xpos = 12'd9;
    host_ypos = 12'd9;
    host_req  = 1'b1;
    vblnk = 1'b1;
    tick();
    tick();
    host_req = 1'b0;
    tick();
    checks++; if (xpos !== 12'd10 || ypos !== 12'd10) begin errors++; $display("FAIL withdraw_pos got %0d,%0d exp 10,10", xpos, ypos); end
    checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL withdraw_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
    frame_end();
    checks++; if (ack_cnt - ack0 !== 0) begin errors++; $display("FAIL withdraw_ack got %0d exp 0", ack_cnt - ack0); end
  endtask

  task automatic test_reset_abort();
    int ack0;
    ack0 = ack_cnt;
    host_xpos = 12'd7;
    host_ypos = 12'd8;
    host_req  = 1'b1;
    vblnk = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    host_req = 1'b0;
    vblnk = 1'b0;
    exp_fc = 8'd0;
    checks++; if (xpos !== 12'd512 || ypos !== 12'd384) begin errors++; $display("FAIL abort_pos got %0d,%0d exp 512,384", xpos, ypos); end
    checks++; if (frame_cnt !== 8'd0 || cursor_en !== 1'b1) begin errors++; $display("FAIL abort_state got fc=%0d en=%b exp fc=0 en=1", frame_cnt, cursor_en); end
    for (int i = 0; i < 4; i++) tick();
    frame_to_commit();
    frame_end();
    checks++; if (ack_cnt - ack0 !== 0) begin errors++; $display("FAIL abort_ack got %0d exp 0", ack_cnt - ack0); end
    checks++; if (xpos !== 12'd512 || frame_cnt !== 8'd0) begin errors++; $display("FAIL abort_pend got x=%0d fc=%0d exp x=512 fc=0", xpos, frame_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 256; f++) begin
      mouse_strobe(12'(f), 12'(f + 1));
      frame_to_commit();
      exp_fc = exp_fc + 8'd1;
      frame_end();
    end
    checks++; if (frame_cnt !== exp_fc || exp_fc !== 8'd0) begin errors++; $display("FAIL wrap_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (xpos !== 12'd255 || ypos !== 12'd256) begin errors++; $display("FAIL wrap_pos got %0d,%0d exp 255,256", xpos, ypos); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    ack_cnt     = 0;
    exp_fc      = 8'd0;
    rst         = 1'b1;
    vblnk       = 1'b0;
    mouse_xpos  = '0;
    mouse_ypos  = '0;
    mouse_valid = 1'b0;
    host_xpos   = '0;
    host_ypos   = '0;
    host_req    = 1'b0;
    test_reset();
    test_mouse();
    test_clamp_rr();
    test_pend_keep();
    test_withdraw();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
